// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through byte FIFO.
// Framing errors and FIFO overruns are reported as one-cycle pulses.
module uart_rx_fifo #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic               sysClk,
  input  logic               sysRst,
  input  logic               Rx,
  output logic [7:0]         RxData,
  output logic               RxData_valid,
  input  logic               RxData_ready,
  output logic [FIFO_AW:0]   RxFIFOFillLevel,
  output logic               FramingError,
  output logic               Overrun
);

  localparam int              DEPTH      = 1 << FIFO_AW;
  localparam logic [15:0]     BIT_TICKS  = 16'(CLK_DIV);
  localparam logic [15:0]     HALF_TICKS = 16'(CLK_DIV / 2);
  localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- line synchronizer and falling-edge detect ----------------
  logic       rx_meta, rx_sync, rx_prev;
  logic [1:0] sync_fill;
  logic       fall;

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= Rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      // The synchronizer's reset value is not a real observation of the line,
      // so a high level only counts once it has propagated through both flops.
      rx_prev   <= rx_sync & sync_fill[1];
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // ---------------- receiver FSM ----------------
  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        push_req, push_req_n;
  logic        fe_q, fe_n;
  logic        expired;

  assign expired = (timer == 16'd1);

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push_req <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values computed by the combinational block.
      state    <= state_n;
      timer    <= timer_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      push_req <= push_req_n;
      fe_q     <= fe_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_n    = state;
    timer_n    = timer;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    push_req_n = 1'b0;
    fe_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          timer_n = HALF_TICKS;
        end
      end
      START: begin
        if (expired) begin
          if (!rx_sync) begin
            state_n   = DATA;
            timer_n   = BIT_TICKS;
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      DATA: begin
        if (expired) begin
          shreg_n[bit_idx] = rx_sync;
          timer_n          = BIT_TICKS;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop-bit leaves half a bit to catch the next start edge.
        if (expired) begin
          state_n    = IDLE;
          timer_n    = '0;
          push_req_n = rx_sync;
          fe_n       = ~rx_sync;
        end else begin
          timer_n = timer - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign FramingError = fe_q;

  // ---------------- FWFT FIFO ----------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, pop, push_ok;

  assign full    = (count == FULL_LVL);
  assign pop     = RxData_valid & RxData_ready;
  assign push_ok = push_req & (~full | pop);
  assign Overrun = push_req & full & ~pop;

  // NOTE: storage has no reset; emptiness is defined by the count alone, and
  // RxData is forced to zero whenever nothing valid is stored.
  always_ff @(posedge sysClk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sysClk or posedge sysRst) begin
    if (sysRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign RxData_valid    = (count != '0);
  assign RxData          = RxData_valid ? mem[rd_ptr] : 8'h00;
  assign RxFIFOFillLevel = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes into a queue,
// a negedge monitor pops and compares whenever the consumer handshake completes.
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 8;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic             sysClk = 1'b0;
  logic             sysRst;
  logic             Rx;
  logic [7:0]       RxData;
  logic             RxData_valid;
  logic             RxData_ready;
  logic [FIFO_AW:0] RxFIFOFillLevel;
  logic             FramingError;
  logic             Overrun;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .sysClk          (sysClk),
    .sysRst          (sysRst),
    .Rx              (Rx),
    .RxData          (RxData),
    .RxData_valid    (RxData_valid),
    .RxData_ready    (RxData_ready),
    .RxFIFOFillLevel (RxFIFOFillLevel),
    .FramingError    (FramingError),
    .Overrun         (Overrun)
  );

  always #5 sysClk = ~sysClk;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    Rx = v;
    repeat (n) tick();
  endtask

  // Reference model: a frame with a good stop bit delivers its byte unless the
  // consumer is stalled and the FIFO already holds DEPTH bytes.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive(1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) drive(b[i], CLK_DIV);
    if (stop) begin
      if (exp_q.size() < DEPTH || RxData_ready) exp_q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    drive(stop, CLK_DIV);
  endtask

  always @(negedge sysClk) begin
    if (!sysRst) begin
      if (FramingError) fe_cnt++;
      if (Overrun) ov_cnt++;
      if (FramingError && Overrun) both_cnt++;
      if (RxData_valid && RxData_ready) begin
        if (exp_q.size() == 0) check("pop_with_empty_model", {31'b0, RxData_valid}, 32'd0);
        else check("pop_data", 32'(RxData), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    sysRst       = 1'b1;
    Rx           = 1'b1;
    RxData_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(RxData_valid), 32'd0);
    check("rst_level", 32'(RxFIFOFillLevel), 32'd0);
    check("rst_data", 32'(RxData), 32'h00);
    check("rst_fe", 32'(FramingError), 32'd0);
    check("rst_ov", 32'(Overrun), 32'd0);
    sysRst = 1'b0;
    repeat (5) tick();

    // single frame held in the FIFO, then one pop
    send_frame(8'hA5, 1'b1);
    repeat (3) tick();
    check("single_valid", 32'(RxData_valid), 32'd1);
    check("single_data", 32'(RxData), 32'hA5);
    check("single_level", 32'(RxFIFOFillLevel), 32'd1);
    RxData_ready = 1'b1;
    tick();
    RxData_ready = 1'b0;
    tick();
    check("single_level_after_pop", 32'(RxFIFOFillLevel), 32'd0);
    check("single_valid_after_pop", 32'(RxData_valid), 32'd0);

    // back-to-back frames, consumer always ready
    RxData_ready = 1'b1;
    send_frame(8'h30, 1'b1);
    send_frame(8'h31, 1'b1);
    send_frame(8'h32, 1'b1);
    repeat (10) tick();
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_fe", 32'(fe_cnt), 32'(exp_fe));
    check("b2b_level", 32'(RxFIFOFillLevel), 32'd0);
    RxData_ready = 1'b0;

    // short low glitch on an idle line
    drive(1'b0, 2);
    drive(1'b1, 3 * CLK_DIV);
    check("glitch_level", 32'(RxFIFOFillLevel), 32'd0);
    check("glitch_valid", 32'(RxData_valid), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'(exp_fe));

    // bad stop bit
    send_frame(8'h55, 1'b0);
    drive(1'b1, CLK_DIV);
    check("fe_pulse_count", 32'(fe_cnt), 32'(exp_fe));
    check("fe_level", 32'(RxFIFOFillLevel), 32'd0);

    // overrun on the fifth frame with a stalled consumer
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (4) tick();
    check("ovr_level", 32'(RxFIFOFillLevel), 32'(DEPTH));
    check("ovr_pulse_count", 32'(ov_cnt), 32'(exp_ov));
    RxData_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    RxData_ready = 1'b0;
    tick();
    check("ovr_drained", 32'(exp_q.size()), 32'd0);
    check("ovr_level_after", 32'(RxFIFOFillLevel), 32'd0);

    // reset during bit 3 with two bytes stored
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("pre_rst_level", 32'(RxFIFOFillLevel), 32'd2);
    begin
      logic [7:0] partial;
      partial = 8'h6B;
      drive(1'b0, CLK_DIV);
      for (int i = 0; i < 3; i++) drive(partial[i], CLK_DIV);
      drive(partial[3], CLK_DIV / 2);
    end
    sysRst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_level", 32'(RxFIFOFillLevel), 32'd0);
    check("midrst_valid", 32'(RxData_valid), 32'd0);
    check("midrst_data", 32'(RxData), 32'h00);
    Rx = 1'b1;
    repeat (3) tick();
    sysRst = 1'b0;
    repeat (5) tick();
    RxData_ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    repeat (5) tick();
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_level", 32'(RxFIFOFillLevel), 32'd0);

    // randomized traffic with occasional framing errors and idle gaps
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop);
      if (!stop) drive(1'b1, CLK_DIV);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (10) tick();
    RxData_ready = 1'b0;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_fe", 32'(fe_cnt), 32'(exp_fe));
    check("rand_ov", 32'(ov_cnt), 32'(exp_ov));
    check("rand_level", 32'(RxFIFOFillLevel), 32'd0);
    check("fe_ov_exclusive", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning system clocks per bit period (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4, meaning log2 of the receive FIFO depth (DEPTH = 2^FIFO_AW = 16).
REQ-003 SHALL have port sysClk, input, 1 bit: the single system clock; all state on its rising edge.
REQ-004 SHALL have port sysRst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port RxData, output, 8 bits: FIFO head byte, valid only while RxData_valid=1.
REQ-007 SHALL have port RxData_valid, output, 1 bit: FIFO not empty.
REQ-008 SHALL have port RxData_ready, input, 1 bit: consumer accepts head byte.
REQ-009 SHALL have port RxFIFOFillLevel, output, FIFO_AW+1 bits: bytes currently stored, 0..DEPTH.
REQ-010 SHALL have port FramingError, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-011 SHALL have port Overrun, output, 1 bit: one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-012 Rx SHALL pass through a two-flop synchronizer reset to 1; all line decisions SHALL use the synchronized value.
REQ-013 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE: a synchronized 1->0 transition SHALL move to START and load the bit timer with CLK_DIV/2 (integer division).
REQ-015 START: on timer expiry, line=0 SHALL move to DATA with timer = CLK_DIV and bit index 0; line=1 (glitch) SHALL return to IDLE with no output.
REQ-016 DATA: on each expiry, the line SHALL be shifted in as bit[index], LSB first, and the timer reloaded to CLK_DIV; after bit 7, the FSM SHALL move to STOP.
REQ-017 STOP: on expiry, the stop bit SHALL be sampled and the FSM SHALL return to IDLE in the same cycle, re-arming at mid-stop-bit so back-to-back frames are received.
REQ-018 Stop sample 1 SHALL request a FIFO push of the assembled byte on the next cycle; stop sample 0 SHALL discard the byte and pulse FramingError for exactly one cycle.
REQ-019 The FIFO SHALL be first-word-fall-through: RxData SHALL show the oldest byte combinationally from storage while RxData_valid=1.
REQ-020 A pop SHALL occur on any cycle with RxData_valid=1 and RxData_ready=1; RxData_ready while empty SHALL have no effect.
REQ-021 Push and pop in the same cycle SHALL both take effect; RxFIFOFillLevel SHALL then be unchanged.
REQ-022 A push while the level equals DEPTH and no pop occurs SHALL drop the new byte, leave the FIFO unchanged, and pulse Overrun for one cycle.
REQ-023 A push while the level equals DEPTH with a simultaneous pop SHALL be accepted.
REQ-024 Read and write pointers SHALL be FIFO_AW bits and wrap modulo DEPTH; RxFIFOFillLevel SHALL be the registered count, updated the cycle after push or pop.
REQ-025 Latency SHALL be as follows: RxData_valid rises 2 cycles after the stop-bit sample cycle (push request cycle, then registered count/pointer update).
REQ-026 FramingError and Overrun SHALL never be asserted in the same cycle.

Reset
REQ-027 While sysRst=1, the FSM SHALL be in IDLE, the timer and bit index SHALL be 0, and the pointers and count SHALL be 0.
REQ-028 While sysRst=1, RxData_valid SHALL be 0, RxFIFOFillLevel SHALL be 0, FramingError SHALL be 0, and Overrun SHALL be 0.
REQ-029 While sysRst=1, RxData SHALL be 8'h00.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release, the line SHALL be ignored until it is seen high and then a fresh falling edge occurs.
REQ-031 FIFO contents SHALL be discarded by reset.

Verification (CLK_DIV=8, FIFO_AW=2)
REQ-032 Single frame 0xA5, stop=1, ready=0 SHALL give RxData_valid=1, RxData=0xA5, and level=1; one ready cycle SHALL then give level=0 and valid=0.
REQ-033 Three back-to-back frames 0x30, 0x31, 0x32 with no idle gap SHALL be popped in order 0x30, 0x31, 0x32 with no FramingError.
REQ-034 A 2-cycle low glitch on idle Rx SHALL produce no push, no error, and a return to IDLE.
REQ-035 Frame 0x55 with stop bit 0 SHALL produce a FramingError pulse of 1 cycle with level remaining 0.
REQ-036 Five frames 0x01..0x05 with ready=0 SHALL give level=4 and one Overrun pulse on the 5th; the pops SHALL then return 0x01..0x04.
REQ-037 sysRst asserted during bit 3 of a frame, with the FIFO holding 2 bytes, SHALL give level=0 and valid=0 immediately; the next clean frame 0x7E SHALL be received correctly.
